// File: rtl/pcie_flush_pkg.sv
// Shared definitions for the PCIe upload FIFO flush sequencer and the reset generator.
package pcie_flush_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_GATE      = 2'd1,
    ST_ASSERT    = 2'd2,
    ST_WAIT_BUSY = 2'd3
  } flush_state_e;

  localparam int DEF_DATA_W          = 64;
  localparam int DEF_GUARD_CYCLES    = 8;
  localparam int DEF_RST_HOLD_CYCLES = 16;
  localparam int DEF_BUSY_SETTLE     = 8;
  localparam int DEF_BUSY_TIMEOUT    = 4096;
  localparam int DEF_CNT_W           = 16;

  // Reset-generator sequencing offsets; both blocks derive their timing from these.
  localparam int RSTGEN_FIFO_TRIG_OFFSET = 5000;
  localparam int RSTGEN_RELEASE_OFFSET   = 5100;
  localparam int RSTGEN_DONE_OFFSET      = 8000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, cleared only by the asynchronous reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/pcie_fifo_flush_ctrl.sv
// Gates the acquisition stream, pulses the upload FIFO reset and waits for the
// FIFO reset-busy flags to clear before re-opening the write path.
module pcie_fifo_flush_ctrl
  import pcie_flush_pkg::*;
#(
  parameter int DATA_W          = DEF_DATA_W,
  parameter int GUARD_CYCLES    = DEF_GUARD_CYCLES,
  parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int BUSY_SETTLE     = DEF_BUSY_SETTLE,
  parameter int BUSY_TIMEOUT    = DEF_BUSY_TIMEOUT,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rst_trig,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  input  logic              fifo_full,
  input  logic              wr_rst_busy,
  input  logic              rd_rst_busy,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_rst,
  output logic              ready,
  output logic              flush_done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int MAX_GR = (GUARD_CYCLES > RST_HOLD_CYCLES) ? GUARD_CYCLES : RST_HOLD_CYCLES;
  localparam int CNT_MAX = (BUSY_TIMEOUT > MAX_GR) ? BUSY_TIMEOUT : MAX_GR;
  localparam int ST_W = $clog2(CNT_MAX + 1);

  flush_state_e    state;
  logic [ST_W-1:0] st_cnt;
  logic            wr_term;
  logic            settled;
  logic            busy_clear;
  logic            timed_out;

  assign wr_term    = din_valid & (state == ST_RUN) & ~fifo_full & ~wr_rst_busy;
  assign settled    = int'(st_cnt) >= BUSY_SETTLE - 1;
  assign busy_clear = settled & ~wr_rst_busy & ~rd_rst_busy;
  assign timed_out  = int'(st_cnt) == BUSY_TIMEOUT - 1;

  // Flush sequencer: one shared state counter, cleared on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      st_cnt      <= '0;
      fifo_rst    <= 1'b0;
      ready       <= 1'b1;
      flush_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      st_cnt     <= st_cnt + ST_W'(1);
      case (state)
        ST_RUN: begin
          st_cnt <= '0;
          if (rst_trig) begin
            state <= ST_GATE;
            ready <= 1'b0;
          end
        end
        ST_GATE: begin
          if (int'(st_cnt) == GUARD_CYCLES - 1) begin
            state    <= ST_ASSERT;
            st_cnt   <= '0;
            fifo_rst <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (int'(st_cnt) == RST_HOLD_CYCLES - 1) begin
            state    <= ST_WAIT_BUSY;
            st_cnt   <= '0;
            fifo_rst <= 1'b0;
          end
        end
        ST_WAIT_BUSY: begin
          // A clean exit on the timeout cycle takes priority over the error.
          if (busy_clear || timed_out) begin
            state      <= ST_RUN;
            st_cnt     <= '0;
            ready      <= 1'b1;
            flush_done <= 1'b1;
            if (!busy_clear) begin
              timeout_err <= 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_RUN;
          st_cnt <= '0;
          ready  <= 1'b1;
        end
      endcase
    end
  end

  // Write path: one register stage between upstream and the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
    end else begin
      fifo_wr_en <= wr_term;
      fifo_din   <= din;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (din_valid & ~wr_term),
    .cnt   (drop_cnt)
  );

endmodule

// File: tb/tb_pcie_fifo_flush_ctrl.sv
// Directed bench for pcie_fifo_flush_ctrl: checkpoint table plus hand-written flush corner cases.
module tb_pcie_fifo_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rst_trig = 1'b0;
  logic        din_valid = 1'b0;
  logic [63:0] din = '0;
  logic        fifo_full = 1'b0;
  logic        wr_rst_busy = 1'b0;
  logic        rd_rst_busy = 1'b0;

  logic        fifo_wr_en, fifo_rst, ready, flush_done, timeout_err;
  logic [63:0] fifo_din;
  logic [15:0] drop_cnt;

  logic        s_wr_en, s_rst, s_ready, s_done, s_terr;
  logic [63:0] s_din;
  logic [3:0]  s_drop;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pcie_fifo_flush_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rst_trig(rst_trig), .din_valid(din_valid), .din(din),
    .fifo_full(fifo_full), .wr_rst_busy(wr_rst_busy), .rd_rst_busy(rd_rst_busy),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_rst(fifo_rst), .ready(ready),
    .flush_done(flush_done), .timeout_err(timeout_err), .drop_cnt(drop_cnt)
  );

  pcie_fifo_flush_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .rst_trig(rst_trig), .din_valid(din_valid), .din(din),
    .fifo_full(fifo_full), .wr_rst_busy(wr_rst_busy), .rd_rst_busy(rd_rst_busy),
    .fifo_wr_en(s_wr_en), .fifo_din(s_din), .fifo_rst(s_rst), .ready(s_ready),
    .flush_done(s_done), .timeout_err(s_terr), .drop_cnt(s_drop)
  );

  typedef struct {
    int   cyc;
    logic wr;
    logic frst;
    logic rdy;
    logic done;
    int   drop;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic trig, input logic valid, input logic full,
                       input logic wb, input logic rb);
    rst_trig    = trig;
    din_valid   = valid;
    fifo_full   = full;
    wr_rst_busy = wb;
    rd_rst_busy = rb;
    din         = 64'hA5A5_0000_0000_0000 | 64'(cyc);
  endtask

  task automatic apply_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int k;
    int done_cnt;

    // Checkpoints for continuous valid, trigger at cycle 100, busy flags low.
    tab.push_back('{50,  1'b1, 1'b0, 1'b1, 1'b0, 0});
    tab.push_back('{100, 1'b1, 1'b0, 1'b1, 1'b0, 0});
    tab.push_back('{101, 1'b1, 1'b0, 1'b0, 1'b0, 0});
    tab.push_back('{102, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    tab.push_back('{108, 1'b0, 1'b0, 1'b0, 1'b0, 7});
    tab.push_back('{109, 1'b0, 1'b1, 1'b0, 1'b0, 8});
    tab.push_back('{124, 1'b0, 1'b1, 1'b0, 1'b0, 23});
    tab.push_back('{125, 1'b0, 1'b0, 1'b0, 1'b0, 24});
    tab.push_back('{132, 1'b0, 1'b0, 1'b0, 1'b0, 31});
    tab.push_back('{133, 1'b0, 1'b0, 1'b1, 1'b1, 32});
    tab.push_back('{134, 1'b1, 1'b0, 1'b1, 1'b0, 32});
    tab.push_back('{140, 1'b1, 1'b0, 1'b1, 1'b0, 32});

    #2;
    apply_reset();
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_fifo_din", fifo_din, 0);
    chk("rst_fifo_rst", fifo_rst, 0);
    chk("rst_ready", ready, 1);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_sat_ready", {s_wr_en, s_rst, s_ready, s_done, s_terr}, 5'b00100);
    chk("rst_sat_din_drop", {s_din, s_drop}, 0);

    k = 0;
    while (cyc < 140) begin
      drive(cyc == 100, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      while (k < tab.size() && tab[k].cyc == cyc) begin
        chk("tab_wr_en", fifo_wr_en, tab[k].wr);
        chk("tab_fifo_rst", fifo_rst, tab[k].frst);
        chk("tab_ready", ready, tab[k].rdy);
        chk("tab_flush_done", flush_done, tab[k].done);
        chk("tab_drop_cnt", drop_cnt, 64'(tab[k].drop));
        chk("tab_fifo_din", fifo_din, 64'hA5A5_0000_0000_0000 | 64'(cyc - 1));
        k++;
      end
    end
    chk("tab_all_applied", k, tab.size());

    // wr_rst_busy held through cycle 200.
    apply_reset();
    while (cyc < 204) begin
      drive(cyc == 100, 1'b0, 1'b0, cyc <= 200, 1'b0);
      tick();
      if (cyc == 133) chk("wbusy_ready_133", ready, 0);
      if (cyc == 201) chk("wbusy_ready_201", ready, 0);
      if (cyc == 202) begin
        chk("wbusy_ready_202", ready, 1);
        chk("wbusy_done_202", flush_done, 1);
        chk("wbusy_terr_202", timeout_err, 0);
      end
      if (cyc == 203) chk("wbusy_done_203", flush_done, 0);
    end

    // rd_rst_busy held forever: timeout after 4096 WAIT_BUSY cycles.
    apply_reset();
    while (cyc < 4223) begin
      drive(cyc == 100, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      if (cyc == 4220) begin
        chk("tmo_ready_4220", ready, 0);
        chk("tmo_terr_4220", timeout_err, 0);
      end
      if (cyc == 4221) begin
        chk("tmo_ready_4221", ready, 1);
        chk("tmo_done_4221", flush_done, 1);
        chk("tmo_terr_4221", timeout_err, 1);
      end
      if (cyc == 4222) begin
        chk("tmo_done_4222", flush_done, 0);
        chk("tmo_terr_sticky", timeout_err, 1);
      end
    end

    // Busy clears on the very last WAIT_BUSY cycle: clean exit wins.
    apply_reset();
    while (cyc < 4222) begin
      drive(cyc == 100, 1'b0, 1'b0, 1'b0, cyc < 4220);
      tick();
      if (cyc == 4221) begin
        chk("tie_ready", ready, 1);
        chk("tie_done", flush_done, 1);
        chk("tie_terr", timeout_err, 0);
      end
    end

    // Re-triggers during GATE and WAIT_BUSY are ignored.
    apply_reset();
    done_cnt = 0;
    while (cyc < 300) begin
      drive(cyc == 100 || cyc == 103 || cyc == 127, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      if (flush_done === 1'b1) done_cnt++;
      if (cyc == 133) chk("retrig_ready_133", ready, 1);
      if (cyc == 200) begin
        chk("retrig_ready_200", ready, 1);
        chk("retrig_wr_200", fifo_wr_en, 1);
      end
    end
    chk("retrig_done_count", done_cnt, 1);
    chk("retrig_drop_cnt", drop_cnt, 32);

    // fifo_full drops, and saturation of a 4-bit drop counter.
    apply_reset();
    while (cyc < 32) begin
      drive(1'b0, 1'b1, cyc >= 10 && cyc < 30, 1'b0, 1'b0);
      tick();
      if (cyc == 15) chk("full_wr_en", fifo_wr_en, 0);
      if (cyc == 20) begin
        chk("full_drop_10", drop_cnt, 10);
        chk("full_sat_drop_10", s_drop, 10);
      end
      if (cyc == 25) chk("full_sat_drop_15", s_drop, 15);
      if (cyc == 26) chk("full_sat_hold", s_drop, 15);
      if (cyc == 30) begin
        chk("full_drop_20", drop_cnt, 20);
        chk("full_sat_drop_20", s_drop, 15);
      end
      if (cyc == 31) chk("full_wr_resume", fifo_wr_en, 1);
    end

    // rst_n mid-ASSERT aborts immediately; a later trigger runs normally.
    apply_reset();
    while (cyc < 115) begin
      drive(cyc == 100, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("abort_pre_fifo_rst", fifo_rst, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_fifo_rst", fifo_rst, 0);
    chk("abort_ready", ready, 1);
    apply_reset();
    while (cyc < 134) begin
      drive(cyc == 100, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      if (cyc == 108) chk("again_rst_108", fifo_rst, 0);
      if (cyc == 109) chk("again_rst_109", fifo_rst, 1);
      if (cyc == 124) chk("again_rst_124", fifo_rst, 1);
      if (cyc == 125) chk("again_rst_125", fifo_rst, 0);
      if (cyc == 133) begin
        chk("again_ready_133", ready, 1);
        chk("again_done_133", flush_done, 1);
        chk("again_drop_133", drop_cnt, 32);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
